// File: rtl/keccak_round_ctrl.sv
// Round/step sequencer for the Keccak-f[1600] datapath: issues theta..iota per round,
// drives the iota round index and state-register write-back, with a per-step watchdog.
module keccak_round_ctrl #(
   parameter int NUM_ROUNDS = 24,
   parameter int TIMEOUT    = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] round,
   output logic [4:0]  step_start,
   input  logic [4:0]  step_valid,
   output logic [2:0]  step_sel,
   output logic        state_we
);

   localparam int WD_W  = $clog2(TIMEOUT) + 1;
   localparam int RND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0]  WD_ONE    = WD_W'(1);
   localparam logic [RND_W-1:0] RND_LAST  = RND_W'(NUM_ROUNDS - 1);
   localparam logic [RND_W-1:0] RND_ONE   = RND_W'(1);
   localparam logic [2:0]       STEP_IOTA = 3'd4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state, state_nxt;
   logic [2:0]       step, step_nxt;
   logic [RND_W-1:0] rnd, rnd_nxt;
   logic [WD_W-1:0]  wd, wd_nxt;
   logic             fin, fin_nxt;
   logic             err_nxt, done_nxt, busy_nxt, we_nxt;
   logic [2:0]       sel_nxt;
   logic [4:0]       start_nxt;
   logic             hit;

   assign round = {{(32-RND_W){1'b0}}, rnd};

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      rnd_nxt   = rnd;
      wd_nxt    = wd;
      fin_nxt   = fin;
      err_nxt   = err;
      sel_nxt   = step_sel;
      we_nxt    = 1'b0;
      hit       = step_valid[step];

      if (abort) begin
         state_nxt = IDLE;
         fin_nxt   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = ISSUE;
                  step_nxt  = '0;
                  rnd_nxt   = '0;
                  err_nxt   = 1'b0;
                  fin_nxt   = 1'b0;
               end
            end
            ISSUE: begin
               state_nxt = WAIT;
               wd_nxt    = '0;
            end
            WAIT: begin
               // The final write-back gets its own cycle so done follows the committed state.
               if (fin) begin
                  state_nxt = DONE;
                  fin_nxt   = 1'b0;
               end else if (hit) begin
                  we_nxt  = 1'b1;
                  sel_nxt = step;
                  if (step != STEP_IOTA) begin
                     step_nxt  = step + 3'd1;
                     state_nxt = ISSUE;
                  end else if (rnd != RND_LAST) begin
                     rnd_nxt   = rnd + RND_ONE;
                     step_nxt  = '0;
                     state_nxt = ISSUE;
                  end else begin
                     fin_nxt = 1'b1;
                  end
               end else if (wd == WD_LAST) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  wd_nxt = wd + WD_ONE;
               end
            end
            DONE: begin
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end

      busy_nxt  = (state_nxt == ISSUE) || (state_nxt == WAIT);
      done_nxt  = (state_nxt == DONE);
      start_nxt = (state_nxt == ISSUE) ? (5'b00001 << step_nxt) : 5'b00000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         step       <= '0;
         rnd        <= '0;
         wd         <= '0;
         fin        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         step_start <= '0;
         step_sel   <= '0;
         state_we   <= 1'b0;
      end else begin
         state      <= state_nxt;
         step       <= step_nxt;
         rnd        <= rnd_nxt;
         wd         <= wd_nxt;
         fin        <= fin_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         step_start <= start_nxt;
         step_sel   <= sel_nxt;
         state_we   <= we_nxt;
      end
   end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Scoreboard bench for keccak_round_ctrl: stimulus queues expected step/write-back/done
// events, a monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_keccak_round_ctrl;

   localparam int NR = 24;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        busy, done, err, state_we;
   logic [31:0] round;
   logic [4:0]  step_start;
   logic [4:0]  step_valid = 5'b0;
   logic [2:0]  step_sel;

   keccak_round_ctrl #(.NUM_ROUNDS(NR), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .busy(busy), .done(done), .err(err), .round(round),
      .step_start(step_start), .step_valid(step_valid),
      .step_sel(step_sel), .state_we(state_we)
   );

   always #5 clk = ~clk;

   typedef struct { logic [4:0] oh; int rnd; int cyc; } ss_t;
   typedef struct { logic [2:0] sel; int rnd; int cyc; } we_t;
   ss_t ss_q[$];
   we_t we_q[$];
   int  done_q[$];

   int tests = 0, fails = 0;
   int edge_cnt = 0, base = 0;
   int busy_first, busy_last, busy_cnt, err_first, done_cnt, we_cnt;

   bit       rand_lat = 0, wrong_en = 0, junk_en = 0, hold_en = 0;
   logic [4:0] pend = 5'b0;
   int       pend_cnt = 0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      edge_cnt++;
   end

   // Step modules: answer each step_start after a (fixed or random) latency.
   initial forever begin
      @(negedge clk);
      step_valid = 5'b0;
      if (pend_cnt > 0) begin
         pend_cnt--;
         if (pend_cnt == 0) step_valid = pend;
         else if (wrong_en) step_valid = ~pend;
      end
      if (step_start != 5'b0) begin
         if (junk_en) step_valid = 5'h1f;
         if (!(hold_en && step_start == 5'b01000 && round == 32'd5)) begin
            pend     = step_start;
            pend_cnt = rand_lat ? int'($urandom_range(1, 10)) : 1;
         end
      end
   end

   // Monitor
   initial forever begin
      int rel;
      @(negedge clk);
      rel = edge_cnt - base;
      if (step_start != 5'b0) begin
         if (ss_q.size() == 0) check("unexpected_step_start", step_start, 0);
         else begin
            ss_t e;
            e = ss_q.pop_front();
            check("ss_onehot", step_start, e.oh);
            check("ss_round", round, e.rnd);
            if (e.cyc >= 0) check("ss_cycle", rel, e.cyc);
         end
      end
      if (state_we) begin
         we_cnt++;
         if (we_q.size() == 0) check("unexpected_state_we", state_we, 0);
         else begin
            we_t w;
            w = we_q.pop_front();
            check("we_sel", step_sel, w.sel);
            check("we_round", round, w.rnd);
            if (w.cyc >= 0) check("we_cycle", rel, w.cyc);
         end
      end
      if (done) begin
         done_cnt++;
         if (done_q.size() == 0) check("unexpected_done", done, 0);
         else begin
            int d;
            d = done_q.pop_front();
            if (d >= 0) check("done_cycle", rel, d);
         end
      end
      if (busy) begin
         if (busy_first < 0) busy_first = rel;
         busy_last = rel;
         busy_cnt++;
      end
      if (err && err_first < 0) err_first = rel;
   end

   task automatic push_exp(input int nss, input int nwe, input bit timed, input bit fin);
      for (int k = 0; k < nss; k++) begin
         ss_t e;
         e.oh  = 5'b00001 << (k % 5);
         e.rnd = k / 5;
         e.cyc = timed ? 1 + 2 * k : -1;
         ss_q.push_back(e);
      end
      for (int k = 0; k < nwe; k++) begin
         we_t w;
         w.sel = 3'(k % 5);
         w.rnd = (k % 5 == 4 && k / 5 < NR - 1) ? k / 5 + 1 : k / 5;
         w.cyc = timed ? 3 + 2 * k : -1;
         we_q.push_back(w);
      end
      if (fin) done_q.push_back(timed ? 2 + 10 * NR : -1);
   endtask

   // Called at a negedge: start is sampled at the next edge, which is cycle 0.
   task automatic begin_run();
      start      = 1'b1;
      base       = edge_cnt;
      busy_first = -1;
      busy_last  = -1;
      busy_cnt   = 0;
      err_first  = -1;
      done_cnt   = 0;
      we_cnt     = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_drained(input string name);
      check({name, "_ss_left"}, ss_q.size(), 0);
      check({name, "_we_left"}, we_q.size(), 0);
      check({name, "_done_left"}, done_q.size(), 0);
   endtask

   task automatic nominal_run(input string name);
      push_exp(5 * NR, 5 * NR, 1, 1);
      begin_run();
      repeat (250) @(negedge clk);
      check_drained(name);
      check({name, "_busy_first"}, busy_first, 1);
      check({name, "_busy_last"}, busy_last, 1 + 10 * NR);
      check({name, "_busy_cnt"}, busy_cnt, 1 + 10 * NR);
      check({name, "_we_cnt"}, we_cnt, 5 * NR);
      check({name, "_done_cnt"}, done_cnt, 1);
      check({name, "_round"}, round, NR - 1);
      check({name, "_err"}, err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running, expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, err, state_we, step_start, step_sel, round}, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal permutation with 1-cycle steps.
      nominal_run("nominal");

      // Random 1..10 latency, wrong-index valids during each wait.
      rand_lat = 1;
      wrong_en = 1;
      push_exp(5 * NR, 5 * NR, 0, 1);
      begin_run();
      for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      rand_lat = 0;
      wrong_en = 0;
      check("rand_done_cnt", done_cnt, 1);
      check("rand_err", err, 0);
      check("rand_round", round, NR - 1);
      check("rand_we_cnt", we_cnt, 5 * NR);
      check_drained("rand");

      // chi withholds valid in round 5: watchdog after 64 WAIT cycles.
      hold_en = 1;
      push_exp(29, 28, 1, 0);
      begin_run();
      repeat (130) @(negedge clk);
      hold_en = 0;
      check("wd_err_cycle", err_first, 122);
      check("wd_err", err, 1);
      check("wd_busy", busy, 0);
      check("wd_busy_last", busy_last, 121);
      check("wd_done_cnt", done_cnt, 0);
      check_drained("wd");
      push_exp(5 * NR, 5 * NR, 1, 1);
      begin_run();
      check("wd_err_cleared", err, 0);
      repeat (249) @(negedge clk);
      check("wd_rerun_done_cnt", done_cnt, 1);
      check("wd_rerun_round", round, NR - 1);
      check_drained("wd_rerun");

      // start while busy and in the DONE cycle, junk valids during ISSUE.
      junk_en = 1;
      push_exp(5 * NR, 5 * NR, 1, 1);
      begin_run();
      for (int c = 1; c < 260; c++) begin
         start = (c == 50 || c == 2 + 10 * NR);
         @(negedge clk);
      end
      start   = 1'b0;
      junk_en = 0;
      check("ign_we_cnt", we_cnt, 5 * NR);
      check("ign_done_cnt", done_cnt, 1);
      check("ign_busy_cnt", busy_cnt, 1 + 10 * NR);
      check("ign_busy_last", busy_last, 1 + 10 * NR);
      check("ign_busy_after", busy, 0);
      check_drained("ign");

      // abort at cycle 100 together with the round-9 iota valid.
      push_exp(50, 49, 1, 0);
      begin_run();
      for (int c = 1; c < 110; c++) begin
         abort = (c == 100);
         if (c == 101) begin
            check("abort_busy", busy, 0);
            check("abort_we", state_we, 0);
            check("abort_round", round, 9);
         end
         @(negedge clk);
      end
      abort = 1'b0;
      check("abort_done_cnt", done_cnt, 0);
      check("abort_round_hold", round, 9);
      check("abort_we_cnt", we_cnt, 49);
      check_drained("abort");

      // Asynchronous reset between edges in cycle 77.
      push_exp(39, 38, 1, 0);
      begin_run();
      repeat (76) @(negedge clk);
      #2 reset = 1'b0;
      #1 check("async_reset_outputs",
               {busy, done, err, state_we, step_start, step_sel, round}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("post_reset_idle",
            {busy, done, err, state_we, step_start, step_sel, round}, 0);
      check("post_reset_done_cnt", done_cnt, 0);
      check_drained("rst");

      nominal_run("after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
